demux_1_x_2_stream: RTL
=======================

# demux_1_x_2_stream

Packet-aware 1-to-2 stream demultiplexer. It is the steering counterpart to the 2:1 selection path. A single valid/ready input stream is routed to one of two valid/ready output channels. The route is chosen by a select bit sampled on the first beat of each packet and held until that packet's last beat. Each output has a one-entry registered holding stage, so the block sits between a producer and two independent consumers with registered outputs and full throughput.

## Interface
- `WIDTH`, 8: data bits per beat.
- `CNT_W`, 8: width of each per-output packet counter.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_data`  input  WIDTH  input beat payload.
- `in_last`  input  1  marks the final beat of a packet.
- `in_sel`  input  1  destination (0 → out0, 1 → out1); sampled only on a packet's first beat.
- `in_valid`  input  1  producer has a beat.
- `in_ready`  output  1  block accepts the beat this cycle.
- `out0_data` / `out1_data`  output  WIDTH  registered payload per channel.
- `out0_last` / `out1_last`  output  1  registered last flag per channel.
- `out0_valid` / `out1_valid`  output  1  channel holding register full.
- `out0_ready` / `out1_ready`  input  1  consumer accepts the beat.
- `busy`  output  1  a multi-beat packet is in progress (state ≠ IDLE).
- `pkt_cnt0` / `pkt_cnt1`  output  CNT_W  count of completed packets accepted for each channel.

## Operation
- A beat is accepted when `in_valid & in_ready`. An output beat completes when `outK_valid & outK_ready`.
- State machine with states IDLE, ROUTE0 and ROUTE1:
  - Target channel: `in_sel` in IDLE, 0 in ROUTE0, 1 in ROUTE1.
  - IDLE, accepted beat with `in_last=0` → ROUTE`in_sel`.
  - IDLE, accepted beat with `in_last=1` → IDLE (single-beat packet).
  - ROUTEk, accepted beat with `in_last=1` → IDLE.
  - In every other case the state holds.
- In ROUTEk, `in_sel` is ignored. Toggling it mid-packet has no effect.
- `in_ready = ~outT_valid | outT_ready`, where T is the target channel.
  - This is a combinational path from `outT_ready`.
  - `in_ready` never depends on `in_valid`.
- Holding register for channel K:
  - Accept routed to K: load `in_data`/`in_last` and set `outK_valid=1`. This happens even if the old beat completes in the same cycle, giving pass-through at one beat per cycle.
  - Else, completion on K: clear `outK_valid`.
  - Else: hold. Data and last stay stable while valid is high and ready is low.
- The non-target channel continues to drain independently while the other channel is being filled.
- `pkt_cnt`k increments by 1 on each accepted beat with `in_last=1` routed to k.
  - Modulo 2^CNT_W; 255 wraps to 0 at the default width.
- `busy = (state != IDLE)`.

## Timing
- Reset (asynchronous assert, synchronous release on the next `clk` edge):
  - State = IDLE.
  - `out0_valid = out1_valid = 0`.
  - `out*_data = 0`, `out*_last = 0`.
  - `pkt_cnt0 = pkt_cnt1 = 0`, `busy = 0`.
  - `in_ready = 1` (both holding registers empty).
- Latency: an input beat accepted at edge N appears as `outK_valid` and data after edge N, i.e. one cycle.
- Throughput: one beat per cycle when the target consumer holds ready high.
- Backpressure: with `outK_ready` low, exactly one beat is buffered in channel K, then `in_ready` drops while K is the target.
- Reset mid-packet: the partial packet is discarded, the buffered beats are dropped, and the counters clear. The next accepted beat is treated as a first beat, so `in_sel` is sampled again.

## Test plan
- Single-beat packet to out0:
  - Stimulus: reset, then drive `in_data=0xA5`, `in_last=1`, `in_sel=0`, `in_valid=1` for 1 cycle, with `out0_ready=1`.
  - Required: `out0_valid=1` with data 0xA5 and last 1 on the next cycle; `pkt_cnt0=1`; `busy` stays 0; `out1_valid` stays 0.
- Three-beat packet to out1 with select toggling:
  - Stimulus: beats 0x11, 0x22, 0x33, with `in_sel` = 1, 0, 0 on the three beats.
  - Required: all three beats appear on out1 in order, with last only on 0x33; `busy=1` for 2 cycles; `pkt_cnt1=1`; out0 never valid.
- Backpressure on out0:
  - Stimulus: `out0_ready=0`, stream 0x01, 0x02.
  - Required: 0x01 is held on `out0_data`; `in_ready=0` from the cycle after acceptance. After raising `out0_ready`, 0x02 follows one cycle after 0x01 completes.
- Independent drain:
  - Stimulus: out1 is full with `out1_ready=0`, then a single-beat packet is sent to out0.
  - Required: the out0 packet is accepted and delivered; `out1_data` stays unchanged.
- Reset mid-packet:
  - Stimulus: assert `rst_n=0` after beat 2 of a 4-beat packet to out1.
  - Required: `out1_valid` drops to 0 immediately (asynchronous) and `busy=0`. A subsequent packet with `in_sel=0` routes to out0.
- Counter wrap:
  - Stimulus: send 256 single-beat packets to out0.
  - Required: `pkt_cnt0` reads 255 after packet 255 and 0 after packet 256; `pkt_cnt1` stays 0.

Source files
------------

// File: rtl/demux_1_x_2_stream.sv
// -----------------------------------------------------------------------------
// demux_1_x_2_stream
// Packet-aware 1-to-2 stream demultiplexer. The destination of a packet is
// taken from in_sel on its first beat and held until its last beat. Each output
// channel has a one-entry registered holding stage, so a channel whose consumer
// keeps ready high passes one beat per cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_data/in_last/in_sel     input beat, end-of-packet flag, destination
//   in_valid / in_ready        input handshake (in_ready is combinational
//                              from the target channel's ready)
//   outK_data/outK_last        registered payload of channel K
//   outK_valid / outK_ready    output handshake of channel K
//   busy                       a multi-beat packet is in progress
//   pkt_cnt0 / pkt_cnt1        completed packets accepted per channel (wraps)
// -----------------------------------------------------------------------------
module demux_1_x_2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ROUTE0 = 2'b01,
        ROUTE1 = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               tgt_s;
    logic               in_ready_s;
    logic               acc_s;
    logic               acc0_s;
    logic               acc1_s;

    logic [WIDTH-1:0]   out0_data_r;
    logic               out0_last_r;
    logic               out0_valid_r;
    logic [WIDTH-1:0]   out1_data_r;
    logic               out1_last_r;
    logic               out1_valid_r;
    logic [CNT_W-1:0]   pkt_cnt0_r;
    logic [CNT_W-1:0]   pkt_cnt1_r;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Target channel: sampled select on a first beat, locked route otherwise.
    always_comb begin
        tgt_s = 1'b0;
        case (state_r)
            IDLE:    tgt_s = in_sel;
            ROUTE0:  tgt_s = 1'b0;
            ROUTE1:  tgt_s = 1'b1;
            default: tgt_s = 1'b0;
        endcase
    end

    // The target can take a beat if its holding stage is empty or draining now.
    assign in_ready_s = tgt_s ? (~out1_valid_r | out1_ready)
                              : (~out0_valid_r | out0_ready);
    assign acc_s      = in_valid & in_ready_s;
    assign acc0_s     = acc_s & ~tgt_s;
    assign acc1_s     = acc_s & tgt_s;

    // Next-state logic for the packet routing FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (acc_s && !in_last) begin
                    state_nxt_s = in_sel ? ROUTE1 : ROUTE0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ROUTE0: begin
                if (acc_s && in_last) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ROUTE0;
                end
            end
            ROUTE1: begin
                if (acc_s && in_last) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ROUTE1;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Channel 0 holding stage: a new load wins over completion (pass-through).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_data_r  <= {WIDTH{1'b0}};
            out0_last_r  <= 1'b0;
            out0_valid_r <= 1'b0;
        end else if (acc0_s) begin
            out0_data_r  <= in_data;
            out0_last_r  <= in_last;
            out0_valid_r <= 1'b1;
        end else if (out0_ready) begin
            out0_valid_r <= 1'b0;
        end
    end

    // Channel 1 holding stage: a new load wins over completion (pass-through).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_data_r  <= {WIDTH{1'b0}};
            out1_last_r  <= 1'b0;
            out1_valid_r <= 1'b0;
        end else if (acc1_s) begin
            out1_data_r  <= in_data;
            out1_last_r  <= in_last;
            out1_valid_r <= 1'b1;
        end else if (out1_ready) begin
            out1_valid_r <= 1'b0;
        end
    end

    // Per-channel completed-packet counters, counted at input acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0_r <= {CNT_W{1'b0}};
            pkt_cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (acc0_s && in_last) begin
                pkt_cnt0_r <= pkt_cnt0_r + CNT_ONE;
            end
            if (acc1_s && in_last) begin
                pkt_cnt1_r <= pkt_cnt1_r + CNT_ONE;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out0_data  = out0_data_r;
    assign out0_last  = out0_last_r;
    assign out0_valid = out0_valid_r;
    assign out1_data  = out1_data_r;
    assign out1_last  = out1_last_r;
    assign out1_valid = out1_valid_r;
    assign busy       = (state_r != IDLE);
    assign pkt_cnt0   = pkt_cnt0_r;
    assign pkt_cnt1   = pkt_cnt1_r;

endmodule
